// File: rtl/booth_coef_mult_if.sv
`default_nettype none
//==============================================================================
// Module   : booth_coef_mult_if
// Summary  : Valid/ready sample and result bus for booth_coef_mult.
// Revision : 1.0  initial release
//==============================================================================
interface booth_coef_mult_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 23,
    parameter int TAG_W  = 4
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic signed [COEF_W-1:0] in_coef;
    logic        [TAG_W-1:0]  in_tag;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic        [TAG_W-1:0]  out_tag;
    logic                     out_sat;

    modport master (
        output in_valid, in_data, in_coef, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_coef, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_sat
    );
endinterface
`default_nettype wire

// File: rtl/booth_coef_mult.sv
`default_nettype none
//==============================================================================
// Module   : booth_coef_mult
// Summary  : 4-stage radix-4 Booth signed multiplier with rounding shift,
//            saturation, tag sideband and valid/ready flow control.
// Revision : 1.0  initial release
//==============================================================================
module booth_coef_mult #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 23,
    parameter int SHIFT  = 0,
    parameter int TAG_W  = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    booth_coef_mult_if.slave  bus
);
    localparam int c_P    = DATA_W + COEF_W;
    localparam int c_NPP  = COEF_W / 2;
    localparam int c_HALF = c_NPP / 2;
    localparam int c_EW   = (c_P + 1 > OUT_W) ? c_P + 1 : OUT_W;

    generate
        if ((COEF_W % 2) != 0 || COEF_W < 4 || OUT_W < 2) begin : g_param_check
            $error("booth_coef_mult: COEF_W must be even and >= 4, OUT_W >= 2");
        end
    endgenerate

    logic w_en;
    logic r_out_valid;
    assign w_en        = !(r_out_valid && !bus.out_ready);
    assign bus.in_ready = w_en;

    // S1: input capture
    logic                     r_v1;
    logic signed [DATA_W-1:0] r_d1;
    logic        [COEF_W-1:0] r_c1;
    logic        [TAG_W-1:0]  r_t1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
            r_c1 <= '0;
            r_t1 <= '0;
        end else if (w_en) begin
            r_v1 <= bus.in_valid;
            r_d1 <= bus.in_data;
            r_c1 <= bus.in_coef;
            r_t1 <= bus.in_tag;
        end
    end

    // S2: Booth digit decode; the implied bit -1 is the appended zero
    logic        [COEF_W:0]   w_cx;
    logic signed [c_P-1:0]    w_dx;
    logic signed [c_P-1:0]    w_pp [c_NPP];

    assign w_cx = {r_c1, 1'b0};

    always_comb begin
        w_dx = {{COEF_W{r_d1[DATA_W-1]}}, r_d1};
        for (int i = 0; i < c_NPP; i++) begin
            case (w_cx[2*i +: 3])
                3'b001, 3'b010: w_pp[i] = w_dx;
                3'b011:         w_pp[i] = w_dx <<< 1;
                3'b100:         w_pp[i] = -(w_dx <<< 1);
                3'b101, 3'b110: w_pp[i] = -w_dx;
                default:        w_pp[i] = '0;
            endcase
        end
    end

    logic                  r_v2;
    logic [TAG_W-1:0]      r_t2;
    logic signed [c_P-1:0] r_pp [c_NPP];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2 <= 1'b0;
            r_t2 <= '0;
            for (int i = 0; i < c_NPP; i++) r_pp[i] <= '0;
        end else if (w_en) begin
            r_v2 <= r_v1;
            r_t2 <= r_t1;
            for (int i = 0; i < c_NPP; i++) r_pp[i] <= w_pp[i] <<< (2 * i);
        end
    end

    // S3: split reduction into low-half and high-half partial sums
    logic signed [c_P-1:0] w_sum0;
    logic signed [c_P-1:0] w_sum1;

    always_comb begin
        w_sum0 = '0;
        w_sum1 = '0;
        for (int i = 0; i < c_NPP; i++) begin
            if (i < c_HALF) w_sum0 = w_sum0 + r_pp[i];
            else            w_sum1 = w_sum1 + r_pp[i];
        end
    end

    logic                  r_v3;
    logic [TAG_W-1:0]      r_t3;
    logic signed [c_P-1:0] r_s0;
    logic signed [c_P-1:0] r_s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v3 <= 1'b0;
            r_t3 <= '0;
            r_s0 <= '0;
            r_s1 <= '0;
        end else if (w_en) begin
            r_v3 <= r_v2;
            r_t3 <= r_t2;
            r_s0 <= w_sum0;
            r_s1 <= w_sum1;
        end
    end

    // S4: final add, round-half-up shift, saturate
    logic signed [c_P-1:0] w_prod;
    logic signed [c_P:0]   w_r;

    assign w_prod = r_s0 + r_s1;

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic [c_P:0] c_RND = (c_P + 1)'(1) << (SHIFT - 1);
            logic signed [c_P:0] w_biased;
            assign w_biased = {w_prod[c_P-1], w_prod} + c_RND;
            assign w_r      = w_biased >>> SHIFT;
        end else begin : g_no_round
            assign w_r = {w_prod[c_P-1], w_prod};
        end
    endgenerate

    logic signed [c_EW-1:0]  w_rx;
    logic signed [c_EW-1:0]  w_max;
    logic signed [c_EW-1:0]  w_min;
    logic signed [OUT_W-1:0] w_out;
    logic                    w_sat;

    always_comb begin
        w_rx               = c_EW'(w_r);
        w_max              = '0;
        w_max[OUT_W-2:0]   = '1;
        w_min              = '1;
        w_min[OUT_W-2:0]   = '0;
        w_sat              = 1'b0;
        w_out              = w_rx[OUT_W-1:0];
        if (w_rx > w_max) begin
            w_out = w_max[OUT_W-1:0];
            w_sat = 1'b1;
        end else if (w_rx < w_min) begin
            w_out = w_min[OUT_W-1:0];
            w_sat = 1'b1;
        end
    end

    logic signed [OUT_W-1:0] r_out_data;
    logic        [TAG_W-1:0] r_out_tag;
    logic                    r_out_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r_v3;
            if (r_v3) begin
                r_out_data <= w_out;
                r_out_tag  <= r_t3;
                r_out_sat  <= w_sat;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_tag   = r_out_tag;
    assign bus.out_sat   = r_out_sat;
endmodule
`default_nettype wire

// File: doc/booth_coef_mult.md
Name: booth_coef_mult

Overview:
- Parametrised, pipelined signed multiplier for the IDCT datapath. Multiplies a two's-complement sample by a two's-complement coefficient supplied per sample.
- Uses radix-4 Booth partial products and a registered adder tree.
- Adds valid/ready flow control, a sideband tag, rounding right-shift and output saturation.
- Sits between the coefficient ROM/transpose buffer and the butterfly accumulators.

Parameters:
- DATA_W, 16, sample width (signed).
- COEF_W, 8, coefficient width (signed); must be even and ≥4.
- OUT_W, 23, result width (signed) after shift.
- SHIFT, 0, arithmetic right shift applied to the full product, with round-half-up.
- TAG_W, 4, sideband tag width carried alongside each sample.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  sample/coef/tag present.
- in_ready  output  1  block accepts input this cycle.
- in_data  input  DATA_W  signed sample.
- in_coef  input  COEF_W  signed coefficient.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- out_data  output  OUT_W  rounded, saturated product.
- out_tag  output  TAG_W  tag of this result.
- out_sat  output  1  result was clipped.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Asserting rst clears all stage valid bits, out_valid, out_data, out_tag and out_sat to 0 immediately.
  - in_ready is 1 while rst is deasserted and no stall exists.
  - Reset mid-operation discards all in-flight samples; nothing is emitted for them.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - stall = out_valid && !out_ready.
  - in_ready = !stall. This is combinational from out_ready and the registered out_valid only.
  - On stall, every pipeline register holds, including valids.
  - Without stall, all stages advance each cycle; bubbles are not collapsed.
  - out_data/out_tag/out_sat are stable while out_valid && !out_ready.
- Pipeline: 4 register stages, latency 4 cycles from accepted input to out_valid with no stall.
  - S1: register data, coef, tag and valid.
  - S2: generate NPP = COEF_W/2 Booth partial products.
    - Digit i is taken from coef bits {2i+1, 2i, 2i−1}, with bit −1 = 0.
    - Digits are in {−2,−1,0,+1,+2}.
    - Each partial product is sign-extended to P = DATA_W+COEF_W bits and pre-shifted by 2i.
    - Negation is via invert plus a correction bit summed in S3 (a full negate is also acceptable); results must be bit-exact.
  - S3: reduce partial products to two P-bit sums: lower half of the PPs and upper half.
  - S4:
    - prod = sum0 + sum1, exact P-bit two's complement; no overflow is possible at width P.
    - If SHIFT>0: r = (prod + 2^(SHIFT−1)) >>> SHIFT, computed at P+1 bits; otherwise r = prod.
    - If r > 2^(OUT_W−1)−1, out_data = max and out_sat = 1.
    - If r < −2^(OUT_W−1), out_data = min and out_sat = 1.
    - Otherwise out_data = r and out_sat = 0.
- Tag: travels with its sample unchanged.
- Coefficient zero: gives 0 with out_sat = 0.
- Extreme operands: coefficient −2^(COEF_W−1) and sample −2^(DATA_W−1) must give the exact product +2^(P−2) before shift and saturation.
- Empty pipeline: out_valid = 0, and out_data holds its last value; don't-care for checking.
- Simultaneous events:
  - Input accept and output drain in the same cycle are legal, and throughput is 1 result per clock.
  - rst overrides everything.
- Elaboration: an elaboration-time check fails if COEF_W is odd or OUT_W < 2.

Test Plan:
- Defaults, directed products:
  - (3, 5) → 15, out_sat=0, out_valid exactly 4 cycles after accept.
  - (−7, 6) → −42.
  - (1234, −128) → −157952.
  - (0, −1) → 0.
- Corner saturation:
  - (−32768, −128) with OUT_W=23 → 4194303, out_sat=1.
  - (−32768, 127) → −4161536, out_sat=0.
- Rounding, SHIFT=4:
  - (3, 5) → 1 (15+8=23>>4).
  - (−3, 5) → −1 (−15+8=−7>>>4).
  - (8, 1) → 1 (8+8=16>>4).
- Backpressure:
  - Stream 8 samples with tags 0..7; hold out_ready=0 for cycles 6–9 after the first accept.
  - Expected: in_ready=0 during the stall, no loss or duplication, tags emerge in order 0..7, outputs stable while stalled.
- Full throughput: out_ready=1 with a continuous random stream of 1000 samples → one result per clock, bit-exact against a reference model.
- Async reset: assert rst mid-stream, between clock edges, with 3 samples in flight → out_valid drops immediately, no result is emitted for those samples, and a new sample accepted after release arrives 4 cycles later.
